// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue interlock between decode and execute.
// Keeps one pending-write counter per architectural register (x1..x31),
// stalls decode on RAW hazards or counter saturation, and sequences a
// drain (fence) that holds issue until every in-flight write has retired.
// Optional performance counters are enabled by defining
// HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [4:0] addr_rs1,
    input  logic [4:0] addr_rs2,
    input  logic       rs1_dependency,
    input  logic       rs2_dependency,
    input  logic [4:0] rd,
    input  logic       rd_write,
    output logic       issue_ready,
    output logic       issue_fire,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       flush,
    input  logic       fence_req,
    output logic       fence_done,
    output logic       busy,
    output logic       wb_error
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] fence_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 exists only to keep indexing simple; it is never written.
    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_next [32];
    state_t           state, state_next;

    logic pend_rs1, pend_rs2, rd_full, hazard;
    logic any_next, wb_err_hit;

    // Hazard detection: a source is pending unless its last write retires now (bypass).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pend_rs1 = 1'b0;
        pend_rs2 = 1'b0;
        if (addr_rs1 != 5'd0)
            pend_rs1 = (cnt[addr_rs1] != '0) &&
                       !(WB_BYPASS && cnt[addr_rs1] == CNT_ONE && wb_valid && wb_rd == addr_rs1);
        if (addr_rs2 != 5'd0)
            pend_rs2 = (cnt[addr_rs2] != '0) &&
                       !(WB_BYPASS && cnt[addr_rs2] == CNT_ONE && wb_valid && wb_rd == addr_rs2);
        // WAW is fine; only a saturated destination counter blocks issue.
        rd_full = rd_write && (rd != 5'd0) && (cnt[rd] == CNT_MAX);
        hazard  = (rs1_dependency && pend_rs1) || (rs2_dependency && pend_rs2) || rd_full;
    end

    assign issue_ready = !hazard && !flush && (state == IDLE);
    assign issue_fire  = issue_valid && issue_ready;

    // Next-state counters: +1 on issue to r, -1 on retire of r, flush clears everything.
    always_comb begin
        any_next   = 1'b0;
        wb_err_hit = wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] == '0);
        for (int r = 0; r < 32; r++) begin
            cnt_next[r] = cnt[r];
            if (r != 0) begin
                if ((issue_fire && rd_write && rd == 5'(r)) &&
                    !(wb_valid && wb_rd == 5'(r) && cnt[r] != '0))
                    cnt_next[r] = cnt[r] + CNT_ONE;
                else if (!(issue_fire && rd_write && rd == 5'(r)) &&
                         (wb_valid && wb_rd == 5'(r) && cnt[r] != '0))
                    cnt_next[r] = cnt[r] - CNT_ONE;
            end
            if (flush)
                cnt_next[r] = '0;
            any_next = any_next || (cnt_next[r] != '0);
        end
    end

    // Fence sequencer next state; flush always returns to IDLE without a done pulse.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fence_req) state_next = DRAIN;
            DRAIN:   if (!any_next) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // State, counters and registered status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            fence_done <= 1'b0;
            busy       <= 1'b0;
            wb_error   <= 1'b0;
            // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any other state.
            for (int r = 0; r < 32; r++)
                cnt[r] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= state_next;
            fence_done <= (state_next == DONE);
            busy       <= any_next;
            wb_error   <= wb_error || wb_err_hit;
            for (int r = 0; r < 32; r++)
                cnt[r] <= cnt_next[r];
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            fence_cycles <= '0;
        end else begin
            if (issue_valid && !issue_ready && state == IDLE)
                stall_cycles <= stall_cycles + 32'd1;
            if (state != IDLE)
                fence_cycles <= fence_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios followed by random
// traffic, all checked against a behavioural model of pending-write counts.
module tb_hazard_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [4:0] addr_rs1 = '0, addr_rs2 = '0, rd = '0, wb_rd = '0;
    logic       rs1_dependency = 1'b0, rs2_dependency = 1'b0, rd_write = 1'b0;
    logic       wb_valid = 1'b0, flush = 1'b0, fence_req = 1'b0;
    logic       issue_ready, issue_fire, fence_done, busy, wb_error;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles, fence_cycles;
`endif

    hazard_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
        .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .rs1_dependency(rs1_dependency), .rs2_dependency(rs2_dependency),
        .rd(rd), .rd_write(rd_write), .issue_ready(issue_ready), .issue_fire(issue_fire),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .fence_req(fence_req),
        .fence_done(fence_done), .busy(busy), .wb_error(wb_error)
`ifdef HAZARD_SCOREBOARD_PERF_EN
        , .stall_cycles(stall_cycles), .fence_cycles(fence_cycles)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: outstanding write count per register, fence phase
    // (0 = accepting issue, 1 = draining, 2 = reporting completion).
    int          m_cnt[32];
    int          m_phase;
    bit          m_busy, m_done, m_err;
    int unsigned m_stall, m_fence;

    task automatic m_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_phase = 0; m_busy = 0; m_done = 0; m_err = 0;
        m_stall = 0; m_fence = 0;
    endtask

    function automatic bit m_pending(input int r);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
        if (m_cnt[r] == 1 && wb_valid && int'(wb_rd) == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = (rs1_dependency && m_pending(int'(addr_rs1))) ||
             (rs2_dependency && m_pending(int'(addr_rs2))) ||
             (rd_write && rd != 0 && m_cnt[rd] == MAX);
        return !hz && !flush && m_phase == 0;
    endfunction

    task automatic m_advance();
        int nxt[32];
        bit fire, rdy, all_zero;
        rdy  = m_ready();
        fire = issue_valid && rdy;
        nxt  = m_cnt;
        if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] == 0) m_err = 1;
        if (fire && rd_write && rd != 0) nxt[rd] = nxt[rd] + 1;
        if (wb_valid && wb_rd != 0 && m_cnt[wb_rd] != 0) nxt[wb_rd] = nxt[wb_rd] - 1;
        if (flush) foreach (nxt[i]) nxt[i] = 0;
        all_zero = 1;
        foreach (nxt[i]) if (nxt[i] != 0) all_zero = 0;
        if (issue_valid && !rdy && m_phase == 0) m_stall++;
        if (m_phase != 0) m_fence++;
        if (flush)              m_phase = 0;
        else if (m_phase == 0)  m_phase = fence_req ? 1 : 0;
        else if (m_phase == 1)  m_phase = all_zero ? 2 : 1;
        else                    m_phase = 0;
        m_done = (m_phase == 2);
        m_busy = !all_zero;
        m_cnt  = nxt;
    endtask

    // Drive one cycle's inputs at the falling edge, then compare all outputs to the model.
    // Argument order: valid, rs1, rs1_dep, rs2, rs2_dep, rd, rd_write, wb_valid, wb_rd, flush, fence_req.
    task automatic drv(input bit iv, input int a1, input bit d1, input int a2, input bit d2,
                       input int dst, input bit rw, input bit wv, input int wr,
                       input bit fl, input bit fr);
        @(negedge clock);
        issue_valid = iv; addr_rs1 = 5'(a1); rs1_dependency = d1;
        addr_rs2 = 5'(a2); rs2_dependency = d2; rd = 5'(dst); rd_write = rw;
        wb_valid = wv; wb_rd = 5'(wr); flush = fl; fence_req = fr;
        #1;
        check("issue_ready", issue_ready, m_ready());
        check("issue_fire", issue_fire, iv && m_ready());
        check("busy", busy, m_busy);
        check("fence_done", fence_done, m_done);
        check("wb_error", wb_error, m_err);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("fence_cycles", fence_cycles, m_fence);
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        m_advance();
    endtask

    task automatic idle_cycle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic issue_to(input int dst);
        drv(1, 0, 0, 0, 0, dst, 1, 0, 0, 0, 0); tick();
    endtask

    task automatic retire(input int wr, input bit fr);
        drv(0, 0, 0, 0, 0, 0, 0, 1, wr, 0, fr); tick();
    endtask

    // Assert reset between clock edges and check the registered outputs drop at once.
    task automatic async_reset();
        @(negedge clock);
        #2;
        issue_valid = 0; fence_req = 0; wb_valid = 0; flush = 0;
        reset_n = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_fence_done", fence_done, 0);
        check("rst_wb_error", wb_error, 0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_fence_cycles", fence_cycles, 0);
`endif
        m_reset();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1;
    endtask

    initial begin
        int fr_r, dst, wr, a1, a2;
        bit iv, d1, d2, rw, wv, fl;
        m_reset();
        #3;
        check("reset_busy", busy, 0);
        check("reset_fence_done", fence_done, 0);
        check("reset_wb_error", wb_error, 0);
        @(negedge clock);
        reset_n = 1;

        // RAW stall and write-back bypass.
        drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        check("raw_first_issue", issue_fire, 1); tick();
        drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("raw_stall", issue_ready, 0); tick();
        drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        check("raw_bypass", issue_ready, 1); tick();
        idle_cycle();

        // Dependency qualifiers gate the hazard.
        issue_to(7);
        drv(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        check("dep_gate_off", issue_ready, 1); tick();
        drv(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        check("dep_gate_on", issue_ready, 0); tick();
        retire(7, 0);

        // Saturation and simultaneous issue/retire on one register.
        issue_to(3); issue_to(3); issue_to(3);
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        check("sat_stall", issue_ready, 0); tick();
        retire(3, 0);
        drv(1, 0, 0, 0, 0, 3, 1, 1, 3, 0, 0);
        check("sat_net_fire", issue_fire, 1); tick();
        retire(3, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        check("sat_one_left", busy, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_drained", busy, 0); tick();

        // x0 is never tracked; retire of an idle register is a sticky error.
        issue_to(0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("x0_busy", busy, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        check("x0_wb_no_error", wb_error, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("err_set", wb_error, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("err_sticky", wb_error, 1); tick();

        // Fence with two writes outstanding on x4.
        issue_to(4); issue_to(4);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("fence_block", issue_ready, 0); tick();
        retire(4, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1);
        check("fence_not_yet", fence_done, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fence_done_pulse", fence_done, 1); tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fence_pulse_end", fence_done, 0);
        check("fence_back_idle", issue_ready, 1); tick();

        // Fence with nothing pending completes two cycles after the request.
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("fence_empty_wait", fence_done, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fence_empty_pulse", fence_done, 1); tick();

        // Flush while draining clears counters and aborts the fence.
        issue_to(1); issue_to(2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("drain_busy", busy, 1); tick();
        drv(1, 0, 0, 0, 0, 1, 1, 1, 2, 1, 1);
        check("flush_blocks", issue_ready, 0); tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_busy", busy, 0);
        check("flush_no_done", fence_done, 0);
        check("flush_idle", issue_ready, 1); tick();

        // Reset in the middle of a drain.
        issue_to(6);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("pre_reset_drain", issue_ready, 0); tick();
        async_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_reset_idle", issue_ready, 1); tick();

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            fr_r = fence_req;
            if (m_phase == 2)                          fr_r = 0;
            else if (!fence_req && $urandom_range(15) == 0) fr_r = 1;
            iv  = $urandom_range(3) != 0;
            a1  = $urandom_range(7); d1 = $urandom_range(1);
            a2  = $urandom_range(7); d2 = $urandom_range(1);
            dst = $urandom_range(7); rw = $urandom_range(3) != 0;
            wv  = $urandom_range(1); wr = $urandom_range(7);
            fl  = $urandom_range(63) == 0;
            drv(iv, a1, d1, a2, d2, dst, rw, wv, wr, fl, fr_r[0]);
            tick();
            if (n == 1500) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
